vend_ctrl_multi: RTL and testbench

//  Parametrised vending controller: accumulates coin credit, accepts a product selection

---
 rtl/vend_ctrl_multi.sv | 190 +++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi
// Vending controller with a parametrised product table. Collects coin credit,
// takes a product selection, hands the product to the dispenser over a
// valid/ready handshake and then pays back any remaining credit one unit per
// hopper handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   coin_in    : 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
//   sel_valid  : single-cycle selection strobe
//   sel_id     : product index for sel_valid
//   cancel     : single-cycle refund request
//   vend_ready : dispenser accepts vend_id
//   chg_ready  : hopper accepts one change unit
//   credit     : current credit
//   vend_valid : dispense request
//   vend_id    : product being dispensed
//   chg_valid  : one change unit offered
//   coin_rej   : pulse, the coin was returned rather than credited
//   sel_err    : pulse, bad index or insufficient credit
//   busy       : high while dispensing or paying change
// All outputs are registered.

module vend_ctrl_multi #(
    parameter int N_PROD = 4,
    parameter int CW = 8,
    parameter int MAX_CREDIT = 15,
    parameter logic [N_PROD*CW-1:0] PRICES = {8'd8, 8'd7, 8'd6, 8'd5},
    localparam int SW = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin_in,
    input  logic          sel_valid,
    input  logic [SW-1:0] sel_id,
    input  logic          cancel,
    input  logic          vend_ready,
    input  logic          chg_ready,
    output logic [CW-1:0] credit,
    output logic          vend_valid,
    output logic [SW-1:0] vend_id,
    output logic          chg_valid,
    output logic          coin_rej,
    output logic          sel_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] credit_n;
    logic [SW-1:0] vend_id_n;
    logic          coin_rej_n;
    logic          sel_err_n;

    logic          coin_present;
    logic [CW-1:0] coin_val;
    logic [CW:0]   coin_sum;
    logic          coin_fits;
    logic [CW-1:0] price;
    logic          sel_in_range;
    logic          sel_ok;

    // Decode the coin and work out whether adding it stays within the
    // credit ceiling. The sum carries one extra bit so an add near the top
    // of the CW range cannot wrap before the comparison.
    always_comb begin
        coin_val = '0;
        case (coin_in)
            2'b01:   coin_val = CW'(1);
            2'b10:   coin_val = CW'(2);
            2'b11:   coin_val = CW'(5);
            default: coin_val = '0;
        endcase
        coin_present = (coin_in != 2'b00);
        coin_sum     = {1'b0, credit} + {1'b0, coin_val};
        coin_fits    = (coin_sum <= (CW+1)'(MAX_CREDIT));
    end

    // Price lookup. Walking the table keeps an out-of-range index from ever
    // producing an out-of-bounds part-select; such an index just reports
    // itself as not in range.
    always_comb begin
        price        = '0;
        sel_in_range = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_id == SW'(i)) begin
                price        = PRICES[i*CW +: CW];
                sel_in_range = 1'b1;
            end
        end
        sel_ok = sel_in_range && (credit >= price);
    end

    // Next-state and next-output logic. Within CREDIT, cancel wins over a
    // selection which wins over a coin; a coin arriving with a winning
    // cancel/selection is bounced, but a coin alongside a failed selection
    // is still credited. While busy every coin bounces and every selection
    // errors.
    always_comb begin
        state_n    = state;
        credit_n   = credit;
        vend_id_n  = vend_id;
        coin_rej_n = 1'b0;
        sel_err_n  = 1'b0;
        case (state)
            IDLE: begin
                sel_err_n = sel_valid;
                if (coin_present) begin
                    if (coin_fits) begin
                        credit_n = coin_sum[CW-1:0];
                        state_n  = CREDIT;
                    end else begin
                        coin_rej_n = 1'b1;
                    end
                end
            end
            CREDIT: begin
                if (cancel) begin
                    state_n    = CHANGE;
                    coin_rej_n = coin_present;
                end else if (sel_valid && sel_ok) begin
                    credit_n   = credit - price;
                    vend_id_n  = sel_id;
                    state_n    = VEND;
                    coin_rej_n = coin_present;
                end else begin
                    sel_err_n = sel_valid;
                    if (coin_present) begin
                        if (coin_fits) begin
                            credit_n = coin_sum[CW-1:0];
                        end else begin
                            coin_rej_n = 1'b1;
                        end
                    end
                end
            end
            VEND: begin
                coin_rej_n = coin_present;
                sel_err_n  = sel_valid;
                if (vend_valid && vend_ready) begin
                    state_n = (credit == '0) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                coin_rej_n = coin_present;
                sel_err_n  = sel_valid;
                if (chg_valid && chg_ready) begin
                    credit_n = credit - CW'(1);
                    if (credit == CW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers. The handshake outputs are taken from the
    // next state so they line up with the state they describe, which gives
    // the one-cycle latency from selection to vend_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            credit     <= '0;
            vend_id    <= '0;
            vend_valid <= 1'b0;
            chg_valid  <= 1'b0;
            coin_rej   <= 1'b0;
            sel_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            credit     <= credit_n;
            vend_id    <= vend_id_n;
            vend_valid <= (state_n == VEND);
            chg_valid  <= (state_n == CHANGE);
            coin_rej   <= coin_rej_n;
            sel_err    <= sel_err_n;
            busy       <= (state_n == VEND) || (state_n == CHANGE);
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Testbench for vend_ctrl_multi: a directed vector table, hand-written
// corner sequences, and a randomized run checked against a reference model.
// A second instance with three products (one priced at 0) covers the
// out-of-range index and zero-price cases.

module tb_vend_ctrl_multi;

    localparam int N_PROD     = 4;
    localparam int CW         = 8;
    localparam int MAX_CREDIT = 15;
    localparam int SW         = 2;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    coin_in;
    logic          sel_valid;
    logic [SW-1:0] sel_id;
    logic          cancel;
    logic          vend_ready;
    logic          chg_ready;
    logic [CW-1:0] credit;
    logic          vend_valid;
    logic [SW-1:0] vend_id;
    logic          chg_valid;
    logic          coin_rej;
    logic          sel_err;
    logic          busy;

    vend_ctrl_multi #(
        .N_PROD(N_PROD), .CW(CW), .MAX_CREDIT(MAX_CREDIT),
        .PRICES({8'd8, 8'd7, 8'd6, 8'd5})
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid),
        .sel_id(sel_id), .cancel(cancel), .vend_ready(vend_ready),
        .chg_ready(chg_ready), .credit(credit), .vend_valid(vend_valid),
        .vend_id(vend_id), .chg_valid(chg_valid), .coin_rej(coin_rej),
        .sel_err(sel_err), .busy(busy)
    );

    // Three-product instance: product 0 = 5, product 1 = 6, product 2 = 0.
    logic          b_rst;
    logic [1:0]    b_coin_in;
    logic          b_sel_valid;
    logic [1:0]    b_sel_id;
    logic          b_cancel;
    logic          b_vend_ready;
    logic          b_chg_ready;
    logic [CW-1:0] b_credit;
    logic          b_vend_valid;
    logic [1:0]    b_vend_id;
    logic          b_chg_valid;
    logic          b_coin_rej;
    logic          b_sel_err;
    logic          b_busy;

    vend_ctrl_multi #(
        .N_PROD(3), .CW(CW), .MAX_CREDIT(MAX_CREDIT),
        .PRICES({8'd0, 8'd6, 8'd5})
    ) dut_b (
        .clk(clk), .rst(b_rst), .coin_in(b_coin_in), .sel_valid(b_sel_valid),
        .sel_id(b_sel_id), .cancel(b_cancel), .vend_ready(b_vend_ready),
        .chg_ready(b_chg_ready), .credit(b_credit), .vend_valid(b_vend_valid),
        .vend_id(b_vend_id), .chg_valid(b_chg_valid), .coin_rej(b_coin_rej),
        .sel_err(b_sel_err), .busy(b_busy)
    );

    typedef struct {
        int rst; int coin; int sel; int sid; int can; int vr; int cr;
        int credit; int vv; int vid; int cv; int rej; int err; int busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: credit plus two flags for "handing over a product"
    // and "paying back change".
    int prices[N_PROD] = '{5, 6, 7, 8};
    int m_credit = 0;
    bit m_vending = 0;
    bit m_refunding = 0;
    int m_vid = 0;
    bit m_rej = 0;
    bit m_err = 0;

    function automatic int coinValue(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic vec_t mk(input int r, input int c, input int s, input int id,
                                input int cn, input int vr, input int cr,
                                input int ecr, input int evv, input int evid,
                                input int ecv, input int erej, input int eerr,
                                input int ebusy);
        vec_t v;
        v.rst = r; v.coin = c; v.sel = s; v.sid = id; v.can = cn; v.vr = vr; v.cr = cr;
        v.credit = ecr; v.vv = evv; v.vid = evid; v.cv = ecv; v.rej = erej;
        v.err = eerr; v.busy = ebusy;
        return v;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input int s, input int id,
                                 input int cn, input int vr, input int cr);
        rst        = 1'(r);
        coin_in    = 2'(c);
        sel_valid  = 1'(s);
        sel_id     = SW'(id);
        cancel     = 1'(cn);
        vend_ready = 1'(vr);
        chg_ready  = 1'(cr);
    endtask

    task automatic checkOutput(input string tag, input int ecr, input int evv, input int evid,
                               input int ecv, input int erej, input int eerr, input int ebusy);
        checkVal({tag, ".credit"},     int'(credit),     ecr);
        checkVal({tag, ".vend_valid"}, int'(vend_valid), evv);
        if (evv != 0) checkVal({tag, ".vend_id"}, int'(vend_id), evid);
        checkVal({tag, ".chg_valid"},  int'(chg_valid),  ecv);
        checkVal({tag, ".coin_rej"},   int'(coin_rej),   erej);
        checkVal({tag, ".sel_err"},    int'(sel_err),    eerr);
        checkVal({tag, ".busy"},       int'(busy),       ebusy);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_credit, int'(m_vending), m_vid, int'(m_refunding),
                    int'(m_rej), int'(m_err), int'(m_vending | m_refunding));
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int cval;
        cval  = coinValue(coin_in);
        m_rej = 0;
        m_err = 0;
        if (rst) begin
            m_credit = 0; m_vending = 0; m_refunding = 0; m_vid = 0;
        end else if (m_vending || m_refunding) begin
            m_rej = (cval != 0);
            m_err = sel_valid;
            if (m_vending) begin
                if (vend_ready) begin
                    m_vending   = 0;
                    m_refunding = (m_credit > 0);
                end
            end else if (chg_ready) begin
                m_credit    = m_credit - 1;
                m_refunding = (m_credit > 0);
            end
        end else if (m_credit > 0 && cancel) begin
            m_refunding = 1;
            m_rej       = (cval != 0);
        end else if (m_credit > 0 && sel_valid && int'(sel_id) < N_PROD &&
                     m_credit >= prices[sel_id]) begin
            m_credit  = m_credit - prices[sel_id];
            m_vid     = int'(sel_id);
            m_vending = 1;
            m_rej     = (cval != 0);
        end else begin
            m_err = sel_valid;
            if (cval != 0) begin
                if (m_credit + cval <= MAX_CREDIT) m_credit = m_credit + cval;
                else m_rej = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic bStep(input int r, input int c, input int s, input int id,
                         input int cn, input int vr, input int cr);
        b_rst        = 1'(r);
        b_coin_in    = 2'(c);
        b_sel_valid  = 1'(s);
        b_sel_id     = 2'(id);
        b_cancel     = 1'(cn);
        b_vend_ready = 1'(vr);
        b_chg_ready  = 1'(cr);
        @(posedge clk);
        #1;
    endtask

    // Main test sequence.
    initial begin
        int units;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        b_rst = 1'b1; b_coin_in = 2'b00; b_sel_valid = 1'b0; b_sel_id = 2'd0;
        b_cancel = 1'b0; b_vend_ready = 1'b0; b_chg_ready = 1'b0;

        // ---- three-product instance: bad index and zero price ----
        bStep(1, 0, 0, 0, 0, 0, 0);
        checkVal("b_reset.credit", int'(b_credit), 0);
        checkVal("b_reset.busy", int'(b_busy), 0);
        bStep(0, 1, 0, 0, 0, 0, 0);
        checkVal("b_coin.credit", int'(b_credit), 1);
        bStep(0, 0, 1, 3, 0, 0, 0);
        checkVal("b_badid.sel_err", int'(b_sel_err), 1);
        checkVal("b_badid.credit", int'(b_credit), 1);
        checkVal("b_badid.vend_valid", int'(b_vend_valid), 0);
        bStep(0, 0, 1, 2, 0, 0, 0);
        checkVal("b_free.vend_valid", int'(b_vend_valid), 1);
        checkVal("b_free.vend_id", int'(b_vend_id), 2);
        checkVal("b_free.credit", int'(b_credit), 1);
        checkVal("b_free.sel_err", int'(b_sel_err), 0);
        bStep(0, 0, 0, 0, 0, 1, 0);
        checkVal("b_free_done.chg_valid", int'(b_chg_valid), 1);
        checkVal("b_free_done.vend_valid", int'(b_vend_valid), 0);
        bStep(0, 0, 0, 0, 0, 0, 1);
        checkVal("b_refund.credit", int'(b_credit), 0);
        checkVal("b_refund.chg_valid", int'(b_chg_valid), 0);
        checkVal("b_refund.busy", int'(b_busy), 0);

        // ---- directed vector table on the four-product instance ----
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 5,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 6,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,1,1,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 5,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 10,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 5,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,1, 5,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1, 4,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1, 3,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1, 2,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 5,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 10,0,0,0,0,0,0));
        vecs.push_back(mk(0,2,0,0,0,0,0, 12,0,0,0,0,0,0));
        vecs.push_back(mk(0,2,0,0,0,0,0, 14,0,0,0,0,0,0));
        vecs.push_back(mk(0,2,0,0,0,0,0, 14,0,0,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 15,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 15,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 5,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,3,0,0,0, 5,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,1,2,0,0,0, 6,0,0,0,0,1,0));
        vecs.push_back(mk(0,3,1,1,0,0,0, 0,1,1,0,1,0,1));
        vecs.push_back(mk(0,2,1,0,0,0,0, 0,1,1,0,1,1,1));
        vecs.push_back(mk(0,0,0,0,1,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,0,1,0));
        vecs.push_back(mk(0,3,0,0,1,0,0, 1,0,0,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].coin, vecs[i].sel, vecs[i].sid,
                          vecs[i].can, vecs[i].vr, vecs[i].cr);
            cycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].credit, vecs[i].vv, vecs[i].vid,
                        vecs[i].cv, vecs[i].rej, vecs[i].err, vecs[i].busy);
            if (vecs[i].rst != 0) checkVal($sformatf("vec%0d.vend_id_rst", i), int'(vend_id), 0);
        end

        // ---- cancel with a coin, refund with chg_ready toggling ----
        applyStimulus(1, 0, 0, 0, 0, 0, 0); cycle();
        applyStimulus(0, 3, 0, 0, 0, 0, 0); cycle();
        applyStimulus(0, 2, 0, 0, 0, 0, 0); cycle();
        checkOutput("cancel_pre", 7, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 3, 0, 0, 1, 0, 0); cycle();
        checkOutput("cancel_coin", 7, 0, 0, 1, 1, 0, 1);
        units = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, (k % 2 == 0) ? 1 : 0);
            if (chg_valid && chg_ready) units++;
            cycle();
            checkModel($sformatf("refund%0d", k));
        end
        checkVal("refund_units", units, 7);
        checkOutput("refund_end", 0, 0, 0, 0, 0, 0, 0);

        // ---- dispenser stalls, coins bounce, reset in the middle of change ----
        applyStimulus(0, 3, 0, 0, 0, 0, 0); cycle();
        applyStimulus(0, 3, 0, 0, 0, 0, 0); cycle();
        applyStimulus(0, 0, 1, 3, 0, 0, 0); cycle();
        checkOutput("stall_start", 2, 1, 3, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, $urandom_range(1, 3), 0, 0, 0, 0, 0);
            cycle();
            checkOutput($sformatf("stall%0d", k), 2, 1, 3, 0, 1, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0); cycle();
        checkOutput("stall_release", 2, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); cycle();
        checkOutput("change_one", 1, 0, 0, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1); cycle();
        checkOutput("rst_mid_change", 0, 0, 0, 0, 0, 0, 0);
        checkVal("rst_mid_change.vend_id", int'(vend_id), 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0); cycle();
        checkOutput("after_rst_idle_sel", 0, 0, 0, 0, 0, 1, 0);

        // ---- randomized run against the reference model ----
        applyStimulus(1, 0, 0, 0, 0, 0, 0); cycle();
        checkModel("rand_reset");
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 79) == 0) ? 1 : 0,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0,
                          ($urandom_range(0, 4) == 0) ? 1 : 0,
                          int'($urandom_range(0, 3)),
                          ($urandom_range(0, 11) == 0) ? 1 : 0,
                          int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)));
            cycle();
            checkModel($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
